apbspi_apb_ctrl_v2: RTL and testbench

APBSPI_APB_CTRL_V2 -- requirements
Module: apbspi_apb_ctrl_v2

---
 rtl/apbspi_pkg.sv | 35 +++
 rtl/apbspi_irq_ctrl.sv | 26 ++
 rtl/apbspi_apb_ctrl_v2.sv | 158 +++++++++++++++
 tb/tb_apbspi_apb_ctrl_v2.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/apbspi_pkg.sv
// apbspi_pkg: register offsets, bit indices and APB FSM state shared by the APB/SPI control slice
package apbspi_pkg;
  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_CR     = 8'h08;
  localparam logic [7:0] OFF_SR     = 8'h0C;
  localparam logic [7:0] OFF_PRESC  = 8'h10;
  localparam logic [7:0] OFF_IRQ_EN = 8'h14;
  localparam logic [7:0] OFF_IRQ    = 8'h18;
  localparam logic [7:0] OFF_CS     = 8'h1C;
  localparam logic [7:0] OFF_THR    = 8'h20;
  localparam logic [7:0] OFF_LVL    = 8'h24;
  localparam int CR_SPIEN     = 0;
  localparam int CR_CPHA      = 1;
  localparam int CR_CPOL      = 2;
  localparam int CR_LSB_FIRST = 3;
  localparam int CR_FLUSH_TX  = 4;
  localparam int CR_FLUSH_RX  = 5;
  localparam int SR_BUSY      = 0;
  localparam int SR_TX_EMPTY  = 1;
  localparam int SR_TX_FULL   = 2;
  localparam int SR_RX_EMPTY  = 3;
  localparam int SR_RX_FULL   = 4;
  localparam int IRQ_TX_EMPTY = 0;
  localparam int IRQ_TX_FULL  = 1;
  localparam int IRQ_RX_EMPTY = 2;
  localparam int IRQ_RX_FULL  = 3;
  localparam int IRQ_TRX_DONE = 4;
  localparam int IRQ_TX_LOW   = 5;
  localparam int IRQ_RX_HIGH  = 6;
  localparam int IRQ_RX_OVR   = 7;
  localparam int IRQ_W        = 8;
  localparam int CS_MANUAL    = 8;
  typedef enum logic [1:0] {IDLE, ACCESS, STALL} apb_state_e;
endpackage

// File: rtl/apbspi_irq_ctrl.sv
// apbspi_irq_ctrl: rising-edge IRQ latches with W1C (set wins) and registered irq; ports pclk/presetn, src levels, ovr pulse, w1c mask, irq_en -> stat, irq
module apbspi_irq_ctrl
  import apbspi_pkg::*;
(
  input  logic             pclk,
  input  logic             presetn,
  input  logic [IRQ_W-2:0] src,
  input  logic             ovr,
  input  logic [IRQ_W-1:0] w1c,
  input  logic [IRQ_W-1:0] irq_en,
  output logic [IRQ_W-1:0] stat,
  output logic             irq
);
  logic [IRQ_W-2:0] prev;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prev <= '0;
      stat <= '0;
      irq  <= 1'b0;
    end else begin
      prev <= src;
      stat <= (stat & ~w1c) | {ovr, src & ~prev};
      irq  <= |(stat & irq_en);
    end
  end
endmodule

// File: rtl/apbspi_apb_ctrl_v2.sv
// apbspi_apb_ctrl_v2: APB slave for an SPI core (regs, FIFO strobes with stall/timeout, CS and IRQ); ports pclk/presetn, APB, FIFO flags/levels/data/strobes, SPI status/controls, spi_cs_n, irq
module apbspi_apb_ctrl_v2
  import apbspi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CS     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int WAIT_MAX   = 255,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  tx_full,
  input  logic                  tx_empty,
  input  logic                  rx_full,
  input  logic                  rx_empty,
  input  logic [LW-1:0]         tx_level,
  input  logic [LW-1:0]         rx_level,
  input  logic                  rx_overrun,
  input  logic [DATA_WIDTH-1:0] rx_rdata,
  output logic [DATA_WIDTH-1:0] tx_wdata,
  output logic                  tx_push,
  output logic                  rx_pop,
  output logic                  tx_flush,
  output logic                  rx_flush,
  input  logic                  spi_busy,
  input  logic                  spi_trx_done,
  output logic                  spi_enable,
  output logic                  spi_cpha,
  output logic                  spi_cpol,
  output logic                  spi_lsb_first,
  output logic [31:0]           spi_prescaler,
  output logic [NUM_CS-1:0]     spi_cs_n,
  output logic                  irq
);
  apb_state_e state, state_n;
  logic [7:0] off;
  logic [31:0] wcnt, rdata;
  logic bad, stall, timeout, done, wr_done;
  logic [3:0] cr;
  logic [7:0] irq_en, tx_thr, rx_thr;
  logic [IRQ_W-1:0] irq_stat, w1c;
  logic [IRQ_W-2:0] src;
  logic [NUM_CS-1:0] cs_mask;
  logic cs_manual;
  logic [4:0] sr;
  logic unused_ok;
  assign unused_ok = ^{paddr[ADDR_WIDTH-1:8], paddr[1:0]};
  assign off = {paddr[7:2], 2'b00};
  always_comb begin
    bad     = (off > OFF_LVL) | (pwrite & ((off == OFF_RXDATA) | (off == OFF_SR) | (off == OFF_LVL)));
    stall   = ~bad & (pwrite ? (off == OFF_TXDATA) & tx_full : (off == OFF_RXDATA) & rx_empty);
    timeout = wcnt >= 32'(WAIT_MAX);
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= (state_n == STALL) ? wcnt + 32'd1 : '0;
    end
  end
  always_comb begin
    state_n = state == IDLE ? ((psel & ~penable) ? ACCESS : IDLE)
            : (pready | ~psel) ? IDLE
            : (penable & stall) ? STALL : state;
  end
  always_comb begin
    pready  = (state != IDLE) & psel & penable & (~stall | timeout);
    pslverr = pready & (bad | stall);
    prdata  = (pready & ~pslverr & ~pwrite) ? rdata : '0;
  end
  assign done     = pready & ~pslverr;
  assign wr_done  = done & pwrite;
  assign tx_push  = wr_done & (off == OFF_TXDATA);
  assign tx_wdata = pwdata[DATA_WIDTH-1:0];
  assign rx_pop   = done & ~pwrite & (off == OFF_RXDATA);
  always_comb begin
    sr = '0;
    sr[SR_BUSY]     = spi_busy;
    sr[SR_TX_EMPTY] = tx_empty;
    sr[SR_TX_FULL]  = tx_full;
    sr[SR_RX_EMPTY] = rx_empty;
    sr[SR_RX_FULL]  = rx_full;
    rdata = off == OFF_RXDATA ? 32'(rx_rdata)
          : off == OFF_CR     ? 32'(cr)
          : off == OFF_SR     ? 32'(sr)
          : off == OFF_PRESC  ? spi_prescaler
          : off == OFF_IRQ_EN ? 32'(irq_en)
          : off == OFF_IRQ    ? 32'(irq_stat)
          : off == OFF_CS     ? 32'({cs_manual, 8'(cs_mask)})
          : off == OFF_THR    ? {16'b0, rx_thr, tx_thr}
          : off == OFF_LVL    ? {16'b0, 8'(rx_level), 8'(tx_level)} : '0;
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cr            <= '0;
      spi_prescaler <= '0;
      irq_en        <= '0;
      cs_mask       <= '0;
      cs_manual     <= 1'b0;
      tx_thr        <= '0;
      rx_thr        <= '0;
      tx_flush      <= 1'b0;
      rx_flush      <= 1'b0;
    end else begin
      tx_flush <= wr_done & (off == OFF_CR) & pwdata[CR_FLUSH_TX];
      rx_flush <= wr_done & (off == OFF_CR) & pwdata[CR_FLUSH_RX];
      if (wr_done && off == OFF_CR) cr <= pwdata[3:0];
      if (wr_done && off == OFF_PRESC) spi_prescaler <= pwdata;
      if (wr_done && off == OFF_IRQ_EN) irq_en <= pwdata[7:0];
      if (wr_done && off == OFF_CS) begin
        cs_mask   <= pwdata[NUM_CS-1:0];
        cs_manual <= pwdata[CS_MANUAL];
      end
      if (wr_done && off == OFF_THR) begin
        tx_thr <= pwdata[7:0];
        rx_thr <= pwdata[15:8];
      end
    end
  end
  assign spi_enable    = cr[CR_SPIEN];
  assign spi_cpha      = cr[CR_CPHA];
  assign spi_cpol      = cr[CR_CPOL];
  assign spi_lsb_first = cr[CR_LSB_FIRST];
  assign spi_cs_n      = cs_manual ? ~cs_mask : ~(cs_mask & {NUM_CS{spi_busy}});
  always_comb begin
    src = '0;
    src[IRQ_TX_EMPTY] = tx_empty;
    src[IRQ_TX_FULL]  = tx_full;
    src[IRQ_RX_EMPTY] = rx_empty;
    src[IRQ_RX_FULL]  = rx_full;
    src[IRQ_TRX_DONE] = spi_trx_done;
    src[IRQ_TX_LOW]   = 8'(tx_level) <= tx_thr;
    src[IRQ_RX_HIGH]  = 8'(rx_level) >= rx_thr;
    w1c = (wr_done && off == OFF_IRQ) ? pwdata[IRQ_W-1:0] : '0;
  end
  apbspi_irq_ctrl u_irq (
    .pclk    (pclk),
    .presetn (presetn),
    .src     (src),
    .ovr     (rx_overrun),
    .w1c     (w1c),
    .irq_en  (irq_en),
    .stat    (irq_stat),
    .irq     (irq)
  );
endmodule

// File: tb/tb_apbspi_apb_ctrl_v2.sv
// tb_apbspi_apb_ctrl_v2: directed self-checking bench for the APB/SPI control slice
module tb_apbspi_apb_ctrl_v2;
  logic pclk = 1'b0;
  logic presetn, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic pready, pslverr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [4:0] tx_level, rx_level;
  logic rx_overrun;
  logic [31:0] rx_rdata, tx_wdata;
  logic tx_push, rx_pop, tx_flush, rx_flush;
  logic spi_busy, spi_trx_done;
  logic spi_enable, spi_cpha, spi_cpol, spi_lsb_first;
  logic [31:0] spi_prescaler;
  logic [3:0] spi_cs_n;
  logic irq;
  int checks = 0, failures = 0;
  int push_cnt = 0, pop_cnt = 0, tflush_cnt = 0, rflush_cnt = 0;
  logic [31:0] last_wdata = '0;

  apbspi_apb_ctrl_v2 #(.WAIT_MAX(4)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .tx_level(tx_level), .rx_level(rx_level), .rx_overrun(rx_overrun),
    .rx_rdata(rx_rdata), .tx_wdata(tx_wdata), .tx_push(tx_push), .rx_pop(rx_pop),
    .tx_flush(tx_flush), .rx_flush(rx_flush), .spi_busy(spi_busy), .spi_trx_done(spi_trx_done),
    .spi_enable(spi_enable), .spi_cpha(spi_cpha), .spi_cpol(spi_cpol),
    .spi_lsb_first(spi_lsb_first), .spi_prescaler(spi_prescaler), .spi_cs_n(spi_cs_n), .irq(irq)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (tx_push) begin
      push_cnt++;
      last_wdata = tx_wdata;
    end
    if (rx_pop) pop_cnt++;
    if (tx_flush) tflush_cnt++;
    if (rx_flush) rflush_cnt++;
  end

  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err, output int waits);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    @(negedge pclk);
    while (!pready && waits < 20) begin
      waits++;
      @(negedge pclk);
    end
    if (!pready) waits = -1;
    rd = prdata;
    err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    tx_full = 0; tx_empty = 1; rx_full = 0; rx_empty = 1; tx_level = '0; rx_level = '0;
    rx_overrun = 0; rx_rdata = '0; spi_busy = 0; spi_trx_done = 0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    checks++; if (spi_cs_n !== 4'hF) begin failures++; $display("FAIL reset_cs_n got=%h exp=f", spi_cs_n); end
    checks++; if ({pready, pslverr, irq, tx_push, rx_pop, tx_flush, rx_flush} !== 7'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0", {pready, pslverr, irq, tx_push, rx_pop, tx_flush, rx_flush}); end
    checks++; if (prdata !== 32'h0 || spi_prescaler !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", prdata, spi_prescaler); end
    @(posedge pclk); #1 presetn = 1'b1;
  endtask

  task automatic test_tx_write();
    logic [31:0] rd; logic err; int w, p;
    p = push_cnt;
    apb_xfer(1, 32'h00, 32'h0000_005A, rd, err, w);
    repeat (2) @(posedge pclk);
    checks++; if (w !== 0 || err !== 1'b0) begin failures++; $display("FAIL tx_write got waits=%0d err=%b exp waits=0 err=0", w, err); end
    checks++; if (push_cnt - p !== 1) begin failures++; $display("FAIL tx_push_count got=%0d exp=1", push_cnt - p); end
    checks++; if (last_wdata !== 32'h5A) begin failures++; $display("FAIL tx_wdata got=%h exp=5a", last_wdata); end
  endtask

  task automatic test_tx_stall();
    logic [31:0] rd; logic err; int w, p;
    p = push_cnt;
    tx_full = 1'b1;
    fork
      apb_xfer(1, 32'h00, 32'h0000_00A5, rd, err, w);
      begin repeat (5) @(posedge pclk); #1 tx_full = 1'b0; end
    join
    repeat (2) @(posedge pclk);
    checks++; if (w !== 3 || err !== 1'b0) begin failures++; $display("FAIL tx_stall got waits=%0d err=%b exp waits=3 err=0", w, err); end
    checks++; if (push_cnt - p !== 1 || last_wdata !== 32'hA5) begin failures++; $display("FAIL tx_stall_push got=%0d/%h exp=1/a5", push_cnt - p, last_wdata); end
  endtask

  task automatic test_rx_read();
    logic [31:0] rd; logic err; int w, p;
    p = pop_cnt;
    rx_empty = 1'b0; rx_rdata = 32'hCAFE_BABE;
    apb_xfer(0, 32'h04, 32'h0, rd, err, w);
    rx_empty = 1'b1;
    checks++; if (rd !== 32'hCAFE_BABE || w !== 0 || err !== 1'b0) begin failures++; $display("FAIL rx_read got=%h waits=%0d err=%b exp=cafebabe/0/0", rd, w, err); end
    checks++; if (pop_cnt - p !== 1) begin failures++; $display("FAIL rx_pop_count got=%0d exp=1", pop_cnt - p); end
  endtask

  task automatic test_rx_timeout();
    logic [31:0] rd; logic err; int w, p;
    p = pop_cnt;
    apb_xfer(0, 32'h04, 32'h0, rd, err, w);
    repeat (2) @(posedge pclk);
    checks++; if (w !== 4 || err !== 1'b1) begin failures++; $display("FAIL rx_timeout got waits=%0d err=%b exp waits=4 err=1", w, err); end
    checks++; if (pop_cnt - p !== 0) begin failures++; $display("FAIL rx_timeout_pop got=%0d exp=0", pop_cnt - p); end
  endtask

  task automatic test_regs();
    logic [31:0] rd; logic err; int w;
    apb_xfer(1, 32'h10, 32'h1234_5678, rd, err, w);
    apb_xfer(0, 32'h10, 32'h0, rd, err, w);
    checks++; if (rd !== 32'h1234_5678 || spi_prescaler !== 32'h1234_5678) begin failures++; $display("FAIL presc got=%h/%h exp=12345678", rd, spi_prescaler); end
    apb_xfer(1, 32'h08, 32'h0000_000F, rd, err, w);
    apb_xfer(0, 32'h08, 32'h0, rd, err, w);
    checks++; if (rd !== 32'h0F || {spi_lsb_first, spi_cpol, spi_cpha, spi_enable} !== 4'hF) begin failures++; $display("FAIL cr got=%h mode=%b exp=0f/1111", rd, {spi_lsb_first, spi_cpol, spi_cpha, spi_enable}); end
    spi_busy = 1; tx_empty = 0; tx_full = 1; rx_empty = 0; rx_full = 1;
    apb_xfer(0, 32'h0C, 32'h0, rd, err, w);
    spi_busy = 0; tx_empty = 1; tx_full = 0; rx_empty = 1; rx_full = 0;
    checks++; if (rd !== 32'h15) begin failures++; $display("FAIL sr got=%h exp=15", rd); end
    tx_level = 5'd5; rx_level = 5'd12;
    apb_xfer(0, 32'h24, 32'h0, rd, err, w);
    checks++; if (rd !== 32'h0C05) begin failures++; $display("FAIL lvl got=%h exp=0c05", rd); end
    apb_xfer(0, 32'h00, 32'h0, rd, err, w);
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL txdata_read got=%h err=%b exp=0/0", rd, err); end
  endtask

  task automatic test_flush();
    logic [31:0] rd; logic err; int w, t, r;
    t = tflush_cnt; r = rflush_cnt;
    apb_xfer(1, 32'h08, 32'h0000_0010, rd, err, w);
    repeat (3) @(posedge pclk);
    checks++; if (tflush_cnt - t !== 1 || rflush_cnt - r !== 0) begin failures++; $display("FAIL tx_flush got=%0d/%0d exp=1/0", tflush_cnt - t, rflush_cnt - r); end
    apb_xfer(0, 32'h08, 32'h0, rd, err, w);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL cr_after_flush got=%h exp=0", rd); end
    t = tflush_cnt;
    apb_xfer(1, 32'h08, 32'h0000_0021, rd, err, w);
    repeat (3) @(posedge pclk);
    apb_xfer(0, 32'h08, 32'h0, rd, err, w);
    checks++; if (rflush_cnt - r !== 1 || tflush_cnt - t !== 0 || rd !== 32'h01) begin failures++; $display("FAIL rx_flush got=%0d/%0d cr=%h exp=1/0/01", rflush_cnt - r, tflush_cnt - t, rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic err; int w;
    apb_xfer(1, 32'h14, 32'h80, rd, err, w);
    @(posedge pclk); #1 rx_overrun = 1'b1;
    @(posedge pclk); #1 rx_overrun = 1'b0;
    @(negedge pclk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_latency got=%b exp=0", irq); end
    @(negedge pclk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
    apb_xfer(1, 32'h18, 32'h80, rd, err, w);
    @(posedge pclk); @(negedge pclk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq); end
    fork
      apb_xfer(1, 32'h18, 32'h80, rd, err, w);
      begin repeat (2) @(posedge pclk); #1 rx_overrun = 1'b1; @(posedge pclk); #1 rx_overrun = 1'b0; end
    join
    apb_xfer(0, 32'h18, 32'h0, rd, err, w);
    checks++; if ((rd & 32'h80) !== 32'h80) begin failures++; $display("FAIL irq_set_wins got=%h exp=80", rd & 32'h80); end
    tx_level = 5'd5;
    apb_xfer(1, 32'h20, 32'h0000_0003, rd, err, w);
    apb_xfer(1, 32'h18, 32'hFF, rd, err, w);
    apb_xfer(0, 32'h18, 32'h0, rd, err, w);
    checks++; if ((rd & 32'hA0) !== 32'h0) begin failures++; $display("FAIL irq_cleared got=%h exp=0", rd & 32'hA0); end
    tx_level = 5'd2;
    repeat (2) @(posedge pclk);
    apb_xfer(0, 32'h18, 32'h0, rd, err, w);
    checks++; if ((rd & 32'h20) !== 32'h20) begin failures++; $display("FAIL irq_tx_low got=%h exp=20", rd & 32'h20); end
  endtask

  task automatic test_cs();
    logic [31:0] rd; logic err; int w;
    apb_xfer(1, 32'h1C, 32'h002, rd, err, w);
    @(negedge pclk);
    checks++; if (spi_cs_n !== 4'hF) begin failures++; $display("FAIL cs_idle got=%h exp=f", spi_cs_n); end
    spi_busy = 1'b1;
    @(negedge pclk);
    checks++; if (spi_cs_n !== 4'hD) begin failures++; $display("FAIL cs_busy got=%h exp=d", spi_cs_n); end
    spi_busy = 1'b0;
    @(negedge pclk);
    checks++; if (spi_cs_n !== 4'hF) begin failures++; $display("FAIL cs_release got=%h exp=f", spi_cs_n); end
    apb_xfer(1, 32'h1C, 32'h105, rd, err, w);
    apb_xfer(0, 32'h1C, 32'h0, rd, err, w);
    checks++; if (spi_cs_n !== 4'hA || rd !== 32'h105) begin failures++; $display("FAIL cs_manual got=%h rd=%h exp=a/105", spi_cs_n, rd); end
    apb_xfer(1, 32'h3C, 32'h1, rd, err, w);
    checks++; if (err !== 1'b1 || w !== 0) begin failures++; $display("FAIL unmapped_write got err=%b waits=%0d exp=1/0", err, w); end
    apb_xfer(1, 32'h0C, 32'h1, rd, err, w);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL sr_write got err=%b exp=1", err); end
    apb_xfer(0, 32'h3C, 32'h0, rd, err, w);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL unmapped_read got err=%b rd=%h exp=1/0", err, rd); end
  endtask

  task automatic test_reset_mid_stall();
    int p;
    p = push_cnt;
    tx_full = 1'b1;
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h00; pwdata = 32'h77;
    @(posedge pclk); #1 penable = 1;
    @(negedge pclk);
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL mid_stall_pready got=%b exp=0", pready); end
    @(posedge pclk); #1;
    presetn = 0; psel = 0; penable = 0;
    @(posedge pclk); #1;
    tx_full = 0; presetn = 1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checks++; if (push_cnt - p !== 0) begin failures++; $display("FAIL mid_stall_push got=%0d exp=0", push_cnt - p); end
    checks++; if (spi_cs_n !== 4'hF) begin failures++; $display("FAIL mid_stall_cs got=%h exp=f", spi_cs_n); end
  endtask

  initial begin
    test_reset();
    test_tx_write();
    test_tx_stall();
    test_rx_read();
    test_rx_timeout();
    test_regs();
    test_flush();
    test_irq();
    test_cs();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
